// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: memOp encodings, arbiter state type and the
// alignment check used by the arbiter, DataMem and the LSU.
package dmem_pkg;

  localparam logic [2:0] M_LB  = 3'd0;
  localparam logic [2:0] M_LH  = 3'd1;
  localparam logic [2:0] M_LW  = 3'd2;
  localparam logic [2:0] M_LBU = 3'd4;
  localparam logic [2:0] M_LHU = 3'd5;
  localparam logic [2:0] M_SB  = 3'd0;
  localparam logic [2:0] M_SH  = 3'd1;
  localparam logic [2:0] M_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    ERR    = 2'd3
  } dmemArbState_t;

  // Unknown encodings (3, 6, 7) report as misaligned so they never reach memory.
  function automatic logic isMisaligned(input logic [1:0] addr, input logic [2:0] memOp);
    case (memOp)
      M_LB, M_LBU: return 1'b0;
      M_LH, M_LHU: return addr[0];
      M_LW:        return (addr != 2'b00);
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: combinational winner plus the priority pointer,
// which moves to the other requester after every grant.
module rr_pick2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] reqValid,
  input  logic       en,
  output logic [1:0] grant
);

  logic prio;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (reqValid == 2'b11) grant = prio ? 2'b10 : 2'b01;
      else                   grant = reqValid;
    end
  end

  // grant[0] set means requester 0 won, so requester 1 gets priority next.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                prio <= 1'b0;
    else if (grant != 2'b00)  prio <= grant[0];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the single-ported
// data memory; one transaction outstanding, misaligned requests answered locally.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        reqValid,
  output logic [1:0]        reqReady,
  input  logic [ADDR_W-1:0] req0Addr,
  input  logic [ADDR_W-1:0] req1Addr,
  input  logic [DATA_W-1:0] req0Wdata,
  input  logic [DATA_W-1:0] req1Wdata,
  input  logic [2:0]        req0MemOp,
  input  logic [2:0]        req1MemOp,
  input  logic              req0We,
  input  logic              req1We,
  output logic [1:0]        rspValid,
  output logic [DATA_W-1:0] rspRdata,
  output logic              rspErr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memDin,
  output logic [2:0]        memOp,
  output logic              memWe,
  input  logic [DATA_W-1:0] memDout
);

  dmemArbState_t     state, nextState;
  logic [1:0]        grant;
  logic              idle;
  logic              accept;
  logic              holdId;
  logic [ADDR_W-1:0] holdAddr;
  logic [DATA_W-1:0] holdWdata;
  logic [2:0]        holdOp;
  logic              holdWe;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic [2:0]        selOp;
  logic              selWe;

  // rstn gates idle so reqReady is low for the whole reset window.
  assign idle = (state == IDLE) && rstn;

  rr_pick2 u_pick (
    .clk      (clk),
    .rstn     (rstn),
    .reqValid (reqValid),
    .en       (idle),
    .grant    (grant)
  );

  assign reqReady = grant;
  assign accept   = (grant != 2'b00);
  assign selAddr  = grant[1] ? req1Addr  : req0Addr;
  assign selWdata = grant[1] ? req1Wdata : req0Wdata;
  assign selOp    = grant[1] ? req1MemOp : req0MemOp;
  assign selWe    = grant[1] ? req1We    : req0We;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = isMisaligned(selAddr[1:0], selOp) ? ERR : ACCESS;
      ACCESS:  nextState = holdWe ? IDLE : RDATA;
      RDATA:   nextState = IDLE;
      ERR:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      holdId    <= 1'b0;
      holdAddr  <= '0;
      holdWdata <= '0;
      holdOp    <= '0;
      holdWe    <= 1'b0;
      rspValid  <= 2'b00;
      rspErr    <= 1'b0;
      rspRdata  <= '0;
    end else begin
      state    <= nextState;
      rspValid <= 2'b00;
      rspErr   <= 1'b0;
      if (accept) begin
        holdId    <= grant[1];
        holdAddr  <= selAddr;
        holdWdata <= selWdata;
        holdOp    <= selOp;
        holdWe    <= selWe;
      end
      // Responses leave on the edge that returns the sequencer to IDLE.
      case (state)
        ACCESS: if (holdWe) begin
          rspValid <= 2'b01 << holdId;
          rspRdata <= '0;
        end
        RDATA: begin
          rspValid <= 2'b01 << holdId;
          rspRdata <= memDout;
        end
        ERR: begin
          rspValid <= 2'b01 << holdId;
          rspErr   <= 1'b1;
          rspRdata <= '0;
        end
        default: ;
      endcase
    end
  end

  // Write enable is decoded from state so an async reset kills it at once.
  assign memWe   = (state == ACCESS) && holdWe;
  assign memAddr = holdAddr;
  assign memDin  = holdWdata;
  assign memOp   = holdOp;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_dmem_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  reqValid;
  logic [1:0]  reqReady;
  logic [31:0] req0Addr, req1Addr, req0Wdata, req1Wdata;
  logic [2:0]  req0MemOp, req1MemOp;
  logic        req0We, req1We;
  logic [1:0]  rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic [31:0] memAddr, memDin, memDout;
  logic [2:0]  memOp;
  logic        memWe;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .reqValid(reqValid), .reqReady(reqReady),
    .req0Addr(req0Addr), .req1Addr(req1Addr),
    .req0Wdata(req0Wdata), .req1Wdata(req1Wdata),
    .req0MemOp(req0MemOp), .req1MemOp(req1MemOp),
    .req0We(req0We), .req1We(req1We),
    .rspValid(rspValid), .rspRdata(rspRdata), .rspErr(rspErr),
    .memAddr(memAddr), .memDin(memDin), .memOp(memOp), .memWe(memWe),
    .memDout(memDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] extendLd(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] op);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    h  = a[1] ? w[31:16] : w[15:0];
    case (op)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'b0, sh[7:0]};
      3'd5:    return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] mergeSt(input logic [31:0] old, input logic [1:0] a,
                                          input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (op)
      3'd0:    r[{a, 3'b000} +: 8] = wd[7:0];
      3'd1:    if (a[1]) r[31:16] = wd[15:0]; else r[15:0] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic alignedOk(input logic [1:0] a, input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd4) ||
           (((op == 3'd1) || (op == 3'd5)) && !a[0]) ||
           ((op == 3'd2) && (a == 2'b00));
  endfunction

  // Memory: read address registered on the edge, data combinational afterwards.
  logic [31:0] mem [0:255] = '{default: '0};
  logic [31:0] rdAddr;
  logic [2:0]  rdOp;
  always @(posedge clk) begin
    rdAddr <= memAddr;
    rdOp   <= memOp;
    if (memWe) mem[memAddr[9:2]] <= mergeSt(mem[memAddr[9:2]], memAddr[1:0], memOp, memDin);
  end
  assign memDout = extendLd(mem[rdAddr[9:2]], rdAddr[1:0], rdOp);

  // Reference model: one transaction at a time, outputs derived from accept cycle.
  logic [31:0] refMem [0:255] = '{default: '0};
  int          cyc = 0;
  int          rspAt = -100, weAt = -100;
  logic        mPrio, mId, mWe, mErr;
  logic [31:0] mAddr, mWdata, lastRd;
  logic [2:0]  mOp;
  logic [1:0]  expReady, expRsp;
  logic        expErr;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rstn) begin
      mPrio = 1'b0; mId = 1'b0; mWe = 1'b0; mErr = 1'b0;
      mAddr = '0; mWdata = '0; mOp = '0; lastRd = '0;
      rspAt = -100; weAt = -100;
      chk("rst_reqReady", {30'b0, reqReady}, 32'd0);
      chk("rst_rspValid", {30'b0, rspValid}, 32'd0);
      chk("rst_rspErr", {31'b0, rspErr}, 32'd0);
      chk("rst_rspRdata", rspRdata, 32'd0);
      chk("rst_memAddr", memAddr, 32'd0);
      chk("rst_memDin", memDin, 32'd0);
      chk("rst_memOp", {29'b0, memOp}, 32'd0);
      chk("rst_memWe", {31'b0, memWe}, 32'd0);
    end else begin
      expRsp = 2'b00;
      expErr = 1'b0;
      if (cyc == rspAt) begin
        expRsp = (mId ? 2'b10 : 2'b01);
        expErr = mErr;
        lastRd = (mErr || mWe) ? 32'd0 : extendLd(refMem[mAddr[9:2]], mAddr[1:0], mOp);
      end
      expReady = 2'b00;
      if (cyc >= rspAt) begin
        if (reqValid == 2'b11) expReady = mPrio ? 2'b10 : 2'b01;
        else                   expReady = reqValid;
      end
      chk("reqReady", {30'b0, reqReady}, {30'b0, expReady});
      chk("rspValid", {30'b0, rspValid}, {30'b0, expRsp});
      chk("rspErr", {31'b0, rspErr}, {31'b0, expErr});
      chk("rspRdata", rspRdata, lastRd);
      chk("memWe", {31'b0, memWe}, {31'b0, (cyc == weAt)});
      chk("memAddr", memAddr, mAddr);
      chk("memDin", memDin, mWdata);
      chk("memOp", {29'b0, memOp}, {29'b0, mOp});
      if (cyc == weAt)
        refMem[mAddr[9:2]] = mergeSt(refMem[mAddr[9:2]], mAddr[1:0], mOp, mWdata);
      if (expReady != 2'b00) begin
        mId    = expReady[1];
        mPrio  = ~mId;
        mAddr  = mId ? req1Addr  : req0Addr;
        mWdata = mId ? req1Wdata : req0Wdata;
        mOp    = mId ? req1MemOp : req0MemOp;
        mWe    = mId ? req1We    : req0We;
        mErr   = !alignedOk(mAddr[1:0], mOp);
        rspAt  = cyc + ((mErr || mWe) ? 2 : 3);
        weAt   = (!mErr && mWe) ? cyc + 1 : -100;
      end
    end
  end

  task automatic setReq(input int id, input logic [31:0] a, input logic [2:0] op,
                        input logic we, input logic [31:0] wd);
    if (id == 0) begin
      req0Addr = a; req0MemOp = op; req0We = we; req0Wdata = wd;
    end else begin
      req1Addr = a; req1MemOp = op; req1We = we; req1Wdata = wd;
    end
    reqValid[id] = 1'b1;
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [2:0] op, input logic we,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    int n;
    setReq(id, a, op, we, wd);
    n = 0;
    do begin @(negedge clk); n++; end while (!reqReady[id] && n < 20);
    chk("ready_wait", {31'b0, reqReady[id]}, 32'd1);
    @(posedge clk); #1;
    reqValid[id] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rspValid[id] && lat < 10);
    rd = rspRdata;
    er = rspErr;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          g [4];
  logic [1:0]  acc;

  initial begin
    rstn = 1'b0; reqValid = 2'b00;
    req0Addr = '0; req1Addr = '0; req0Wdata = '0; req1Wdata = '0;
    req0MemOp = '0; req1MemOp = '0; req0We = 1'b0; req1We = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Only requester 1 after reset: granted at once, pointer then favours 0.
    issue(1, 32'h100, 3'd2, 1'b1, 32'h0000_80FF, rd, er, lat);
    chk("sw_lat", lat, 32'd2);
    issue(1, 32'h101, 3'd0, 1'b0, 32'h0, rd, er, lat);
    chk("lb_data", rd, 32'hFFFF_FF80);
    chk("lb_lat", lat, 32'd3);

    setReq(0, 32'h100, 3'd2, 1'b0, 32'h0);
    setReq(1, 32'h104, 3'd2, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) g[i] = -1;
    begin
      int k, n;
      k = 0; n = 0;
      while (k < 4 && n < 60) begin
        @(negedge clk); n++;
        if (reqReady != 2'b00) begin g[k] = int'(reqReady[1]); k++; end
      end
    end
    @(posedge clk); #1;
    reqValid = 2'b00;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk("rr_grant", g[i], i % 2);

    issue(0, 32'h100, 3'd2, 1'b1, 32'hDEAD_BEEF, rd, er, lat);
    issue(0, 32'h100, 3'd2, 1'b0, 32'h0, rd, er, lat);
    chk("lw_data", rd, 32'hDEAD_BEEF);
    chk("lw_lat", lat, 32'd3);
    issue(0, 32'h100, 3'd2, 1'b1, 32'hABCD_0000, rd, er, lat);
    issue(1, 32'h102, 3'd5, 1'b0, 32'h0, rd, er, lat);
    chk("lhu_data", rd, 32'h0000_ABCD);

    issue(0, 32'h200, 3'd2, 1'b1, 32'h1122_3344, rd, er, lat);
    issue(0, 32'h203, 3'd0, 1'b1, 32'h0000_005A, rd, er, lat);
    chk("sb_lat", lat, 32'd2);
    chk("sb_rdata", rd, 32'h0);
    issue(0, 32'h200, 3'd2, 1'b0, 32'h0, rd, er, lat);
    chk("sb_readback", rd, 32'h5A22_3344);

    issue(0, 32'h300, 3'd2, 1'b1, 32'h5566_7788, rd, er, lat);
    issue(0, 32'h102, 3'd2, 1'b0, 32'h0, rd, er, lat);
    chk("mis_lw_err", {31'b0, er}, 32'd1);
    chk("mis_lw_rdata", rd, 32'h0);
    chk("mis_lw_lat", lat, 32'd2);
    issue(1, 32'h301, 3'd1, 1'b1, 32'h0000_FFFF, rd, er, lat);
    chk("mis_sh_err", {31'b0, er}, 32'd1);
    chk("mis_sh_lat", lat, 32'd2);
    issue(0, 32'h300, 3'd2, 1'b0, 32'h0, rd, er, lat);
    chk("mis_sh_unchanged", rd, 32'h5566_7788);
    chk("mis_sh_err_clear", {31'b0, er}, 32'd0);

    // Reset asserted in the ACCESS cycle of a store.
    issue(0, 32'h210, 3'd2, 1'b1, 32'hCAFE_F00D, rd, er, lat);
    setReq(0, 32'h210, 3'd2, 1'b1, 32'h1234_5678);
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!reqReady[0] && n < 20);
      chk("rst_ready_wait", {31'b0, reqReady[0]}, 32'd1);
    end
    @(posedge clk); #1;
    reqValid = 2'b00;
    chk("access_we", {31'b0, memWe}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_we_drop", {31'b0, memWe}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    chk("post_rst_memAddr", memAddr, 32'h0);
    chk("post_rst_rspValid", {30'b0, rspValid}, 32'd0);
    @(posedge clk); #1;
    issue(0, 32'h210, 3'd2, 1'b0, 32'h0, rd, er, lat);
    chk("post_rst_readback", rd, 32'hCAFE_F00D);

    // Random traffic on both requesters, checked cycle by cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = reqValid & reqReady;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] || !reqValid[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            logic [2:0] op;
            int r;
            r = $urandom_range(0, 15);
            op = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 10) ? 3'd2 : (r < 12) ? 3'd4 :
                 (r < 14) ? 3'd5 : (r < 15) ? 3'd3 : 3'd6;
            setReq(i, 32'h100 + $urandom_range(0, 63), op,
                   (op <= 3'd2) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom);
          end else begin
            reqValid[i] = 1'b0;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          reqValid[i] = 1'b0;
        end
      end
    end
    reqValid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
